// File: rtl/serial_servo_cmd_ctrl_if.sv
// Handshake bundle between the servo command sequencer and the UART/PWM datapath.
// The slave modport is the sequencer's view; the master modport is the datapath's view.
interface serial_servo_cmd_ctrl_if #(
  parameter int N_BITS = 7
);
  logic              fim_rx;
  logic [N_BITS-1:0] dado_rx;
  logic              parity_ok;
  logic              pronto_tx;
  logic              partida_tx;
  logic [N_BITS-1:0] dado_tx;
  logic [2:0]        posicao;
  logic              atualiza_pos;
  logic              ocupado;
  logic              overrun;
  logic [3:0]        n_erros;
  logic [3:0]        db_estado;

  modport slave (
    input  fim_rx, dado_rx, parity_ok, pronto_tx,
    output partida_tx, dado_tx, posicao, atualiza_pos, ocupado, overrun, n_erros, db_estado
  );

  modport master (
    output fim_rx, dado_rx, parity_ok, pronto_tx,
    input  partida_tx, dado_tx, posicao, atualiza_pos, ocupado, overrun, n_erros, db_estado
  );
endinterface

// File: rtl/serial_servo_cmd_ctrl.sv
// Servo command sequencer: decodes received characters, moves the servo, waits for it
// to settle and answers with ACK, NAK or the current position digit.
module serial_servo_cmd_ctrl #(
  parameter int                N_BITS        = 7,
  parameter int                SETTLE_CYCLES = 25_000_000,
  parameter logic [2:0]        POS_INICIAL   = 3'd0,
  parameter logic [N_BITS-1:0] ACK_CHAR      = N_BITS'(7'h4B),
  parameter logic [N_BITS-1:0] NAK_CHAR      = N_BITS'(7'h45)
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  serial_servo_cmd_ctrl_if.slave io_bus
);

  localparam int              CNT_W    = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    ESPERA     = 4'd1,
    DECODIFICA = 4'd2,
    ATUALIZA   = 4'd3,
    ASSENTA    = 4'd4,
    TRANSMITE  = 4'd5,
    AGUARDA_TX = 4'd6
  } state_t;

  state_t            r_state, w_next;
  logic [N_BITS-1:0] r_char, w_char;
  logic              r_par, w_par;
  logic [N_BITS-1:0] r_dado_tx, w_dado_tx;
  logic [2:0]        r_posicao, w_posicao;
  logic [3:0]        r_n_erros, w_n_erros;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic              r_overrun, w_overrun;
  logic              r_atualiza_pos;
  logic              r_partida_tx;
  logic              r_ocupado;
  logic              w_is_digit;
  logic              w_is_query;

  assign w_is_digit = r_par && (r_char >= N_BITS'(7'h30)) && (r_char <= N_BITS'(7'h37));
  assign w_is_query = r_par && (r_char == N_BITS'(7'h3F));

  // Next-state and next-value logic for the sequencer and its datapath registers.
  always_comb begin
    w_next    = r_state;
    w_char    = r_char;
    w_par     = r_par;
    w_dado_tx = r_dado_tx;
    w_posicao = r_posicao;
    w_n_erros = r_n_erros;
    w_cnt     = r_cnt;
    // Any character arriving while not idle is lost; flag it until reset.
    w_overrun = r_overrun | (io_bus.fim_rx && (r_state != ESPERA));
    case (r_state)
      INICIAL: begin
        w_next = ESPERA;
      end
      ESPERA: begin
        if (io_bus.fim_rx) begin
          w_char = io_bus.dado_rx;
          w_par  = io_bus.parity_ok;
          w_next = DECODIFICA;
        end else begin
          w_next = ESPERA;
        end
      end
      DECODIFICA: begin
        if (w_is_digit) begin
          w_next = ATUALIZA;
        end else if (w_is_query) begin
          w_dado_tx = N_BITS'(7'h30) + N_BITS'(r_posicao);
          w_next    = TRANSMITE;
        end else begin
          w_dado_tx = NAK_CHAR;
          if (r_n_erros != 4'd15) begin
            w_n_erros = r_n_erros + 4'd1;
          end else begin
            w_n_erros = r_n_erros;
          end
          w_next = TRANSMITE;
        end
      end
      ATUALIZA: begin
        w_posicao = r_char[2:0];
        w_cnt     = '0;
        w_next    = ASSENTA;
      end
      ASSENTA: begin
        if (r_cnt == CNT_LAST) begin
          w_dado_tx = ACK_CHAR;
          w_next    = TRANSMITE;
        end else begin
          w_cnt  = r_cnt + CNT_W'(1);
          w_next = ASSENTA;
        end
      end
      TRANSMITE: begin
        w_next = AGUARDA_TX;
      end
      AGUARDA_TX: begin
        if (io_bus.pronto_tx) begin
          w_next = ESPERA;
        end else begin
          w_next = AGUARDA_TX;
        end
      end
      default: begin
        w_next = INICIAL;
      end
    endcase
  end

  // State and output registers; pulses are registered on the edge leaving their state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= INICIAL;
      r_char         <= '0;
      r_par          <= 1'b0;
      r_dado_tx      <= '0;
      r_posicao      <= POS_INICIAL;
      r_n_erros      <= 4'd0;
      r_cnt          <= '0;
      r_overrun      <= 1'b0;
      r_atualiza_pos <= 1'b0;
      r_partida_tx   <= 1'b0;
      r_ocupado      <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_char         <= w_char;
      r_par          <= w_par;
      r_dado_tx      <= w_dado_tx;
      r_posicao      <= w_posicao;
      r_n_erros      <= w_n_erros;
      r_cnt          <= w_cnt;
      r_overrun      <= w_overrun;
      r_atualiza_pos <= (r_state == ATUALIZA);
      r_partida_tx   <= (r_state == TRANSMITE);
      r_ocupado      <= (w_next != ESPERA);
    end
  end

  assign io_bus.partida_tx   = r_partida_tx;
  assign io_bus.dado_tx      = r_dado_tx;
  assign io_bus.posicao      = r_posicao;
  assign io_bus.atualiza_pos = r_atualiza_pos;
  assign io_bus.ocupado      = r_ocupado;
  assign io_bus.overrun      = r_overrun;
  assign io_bus.n_erros      = r_n_erros;
  assign io_bus.db_estado    = r_state;

endmodule

// File: tb/tb_serial_servo_cmd_ctrl.sv
// Randomized bench for serial_servo_cmd_ctrl against a command-level reference model
// (reply character, reply latency, position, error count and overrun flag per command).
module tb_serial_servo_cmd_ctrl;
  localparam int         S   = 4;
  localparam logic [6:0] ACK = 7'h4B;
  localparam logic [6:0] NAK = 7'h45;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_servo_cmd_ctrl_if #(.N_BITS(7)) bus();

  serial_servo_cmd_ctrl #(
    .N_BITS(7), .SETTLE_CYCLES(S), .POS_INICIAL(3'd0), .ACK_CHAR(ACK), .NAK_CHAR(NAK)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .io_bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int m_pos;
  int m_nerr;
  bit m_ovr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One command issued from idle; inj also throws stray characters and pronto pulses at a busy DUT.
  task automatic run_cmd(input logic [6:0] c, input bit par, input bit inj);
    bit         mv, q;
    int         lat, k_atu, k_part, pos_atu, d;
    logic [6:0] exp_ch;
    mv  = par && (c >= 7'h30) && (c <= 7'h37);
    q   = par && (c == 7'h3F);
    lat = mv ? S + 3 : 2;
    if (mv)     exp_ch = ACK;
    else if (q) exp_ch = 7'h30 + 7'(m_pos);
    else        exp_ch = NAK;
    k_atu = -1; k_part = -1; pos_atu = -1;

    bus.fim_rx = 1'b1; bus.dado_rx = c; bus.parity_ok = par;
    @(negedge clk);
    bus.fim_rx = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (inj && k == 1) begin
        bus.fim_rx = 1'b1; bus.dado_rx = 7'h37; bus.parity_ok = 1'b1;
      end else if (inj && k == 2) begin
        bus.fim_rx = 1'b0;
      end else if (inj && mv && k == 4) begin
        bus.fim_rx = 1'b1; bus.dado_rx = 7'h31; bus.pronto_tx = 1'b1;
      end else if (inj && mv && k == 5) begin
        bus.fim_rx = 1'b0; bus.pronto_tx = 1'b0;
      end
      if (bus.atualiza_pos === 1'b1) begin
        k_atu = k; pos_atu = int'(bus.posicao);
      end
      if (bus.partida_tx === 1'b1) begin
        k_part = k;
        break;
      end
      @(negedge clk);
    end
    check_val("partida_latency", k_part, lat);
    check_val("dado_tx", bus.dado_tx, exp_ch);
    if (mv) begin
      check_val("atualiza_latency", k_atu, 2);
      check_val("posicao_at_pulse", pos_atu, int'(c[2:0]));
      m_pos = int'(c[2:0]);
    end else begin
      check_val("no_atualiza", k_atu, -1);
    end
    if (!mv && !q && m_nerr < 15) m_nerr++;
    if (inj) m_ovr = 1'b1;

    d = $urandom_range(0, 4);
    for (int j = 0; j < d; j++) begin
      @(negedge clk);
      check_val("partida_one_cycle", bus.partida_tx, 1'b0);
      check_val("ocupado_wait", bus.ocupado, 1'b1);
      check_val("dado_tx_stable", bus.dado_tx, exp_ch);
    end
    bus.pronto_tx = 1'b1;
    if (inj) begin
      bus.fim_rx = 1'b1; bus.dado_rx = 7'h30; bus.parity_ok = 1'b1;
    end
    @(negedge clk);
    bus.pronto_tx = 1'b0; bus.fim_rx = 1'b0;
    check_val("back_to_espera", bus.db_estado, 4'd1);
    check_val("ocupado_idle", bus.ocupado, 1'b0);
    check_val("partida_idle", bus.partida_tx, 1'b0);
    check_val("posicao", bus.posicao, m_pos);
    check_val("n_erros", bus.n_erros, m_nerr);
    check_val("overrun", bus.overrun, m_ovr);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_estado"}, bus.db_estado, 4'd0);
    check_val({tag, "_posicao"}, bus.posicao, 3'd0);
    check_val({tag, "_partida"}, bus.partida_tx, 1'b0);
    check_val({tag, "_atualiza"}, bus.atualiza_pos, 1'b0);
    check_val({tag, "_overrun"}, bus.overrun, 1'b0);
    check_val({tag, "_n_erros"}, bus.n_erros, 4'd0);
    check_val({tag, "_ocupado"}, bus.ocupado, 1'b0);
  endtask

  // Abort a sequence with reset: a move caught in settling, or a NAK waiting on the transmitter.
  task automatic reset_mid(input bit in_aguarda);
    bus.fim_rx = 1'b1; bus.parity_ok = 1'b1;
    bus.dado_rx = in_aguarda ? 7'h58 : 7'h36;
    @(negedge clk);
    bus.fim_rx = 1'b0;
    repeat (3) @(negedge clk);
    check_val(in_aguarda ? "pre_reset_aguarda" : "pre_reset_assenta", bus.db_estado,
              in_aguarda ? 4'd6 : 4'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state(in_aguarda ? "rst_aguarda" : "rst_assenta");
    m_pos = 0; m_nerr = 0; m_ovr = 1'b0;
    @(negedge clk);
    check_val("post_reset_espera", bus.db_estado, 4'd1);
  endtask

  initial begin
    logic [6:0] c;
    bit         par, inj;
    int         sel;
    rst = 1'b1;
    bus.fim_rx = 1'b0; bus.dado_rx = 7'h00; bus.parity_ok = 1'b0; bus.pronto_tx = 1'b0;
    m_pos = 0; m_nerr = 0; m_ovr = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    check_val("reset_dado_tx", bus.dado_tx, 7'h00);
    rst = 1'b0;
    @(negedge clk);
    check_val("inicial_to_espera", bus.db_estado, 4'd1);

    run_cmd(7'h35, 1'b1, 1'b0);
    run_cmd(7'h33, 1'b1, 1'b0);
    run_cmd(7'h3F, 1'b1, 1'b0);
    run_cmd(7'h41, 1'b1, 1'b0);
    run_cmd(7'h39, 1'b1, 1'b0);
    run_cmd(7'h32, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      run_cmd(7'h41 + 7'(i), 1'b1, 1'b0);
    end
    run_cmd(7'h33, 1'b1, 1'b0);
    run_cmd(7'h36, 1'b1, 1'b1);
    run_cmd(7'h3F, 1'b1, 1'b0);

    reset_mid(1'b0);
    reset_mid(1'b1);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       c = 7'h3F;
        1:       c = 7'($urandom_range(0, 127));
        default: c = 7'h30 + 7'($urandom_range(0, 7));
      endcase
      par = ($urandom_range(0, 4) != 0);
      inj = ($urandom_range(0, 3) == 0);
      run_cmd(c, par, inj);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
